text_scroller: RTL and testbench

Upstream character source for the `Decoder7Segment_expand` digits. It holds a short message of 6-bit character codes (0x00–0x09 digits, 0x0A–0x23 letters A–Z, 0x3F blank) and scrolls it right-to-left across `DIGITS` display positions at a programmable rate. It presents one registered 6-bit code per digit, one code per decoder instance.

---
 rtl/text_scroller.sv | 156 +++++++++++++++
 tb/tb_text_scroller.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_scroller.sv
// text_scroller
//   Holds a short message of 6-bit character codes and scrolls it right-to-left
//   across DIGITS display positions, one scroll step every TICK_DIV cycles.
//   The message is followed by DIGITS blanks on a circular virtual tape.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   wr_en     message buffer write strobe
//   wr_addr   buffer entry to write
//   wr_data   6-bit character code to write
//   msg_len   message length, sampled on start (clamped to MSG_DEPTH)
//   start     one-cycle pulse: begin / restart scrolling
//   stop      one-cycle pulse: halt and blank (wins over start)
//   char_out  registered codes, digit 0 (leftmost) in the MSBs
//   busy      high while scrolling
//   wrap      one-cycle pulse when the scroll position returns to 0
module text_scroller #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned MSG_DEPTH = 16,
   parameter int unsigned TICK_DIV  = 25_000_000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
   input  logic [5:0]                   wr_data,
   input  logic [$clog2(MSG_DEPTH):0]   msg_len,
   input  logic                         start,
   input  logic                         stop,
   output logic [6*DIGITS-1:0]          char_out,
   output logic                         busy,
   output logic                         wrap
);

   localparam int unsigned AW = $clog2(MSG_DEPTH);
   // Wide enough for pos + DIGITS - 1, which is below 2 * (MSG_DEPTH + DIGITS).
   localparam int unsigned PW = $clog2(MSG_DEPTH + DIGITS) + 1;
   localparam int unsigned CW = $clog2(TICK_DIV);

   localparam logic [5:0]          BLANK      = 6'h3F;
   localparam logic [6*DIGITS-1:0] ALL_BLANK  = {DIGITS{BLANK}};
   localparam logic [AW:0]         DEPTH_L    = (AW+1)'(MSG_DEPTH);
   localparam logic [CW-1:0]       CNT_LAST   = CW'(TICK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state, state_d;
   logic [PW-1:0]       pos, pos_d;
   logic [CW-1:0]       cnt, cnt_d;
   logic [AW:0]         len_q, len_d;
   logic [6*DIGITS-1:0] char_d;
   logic                wrap_d;

   logic [5:0]          mem [MSG_DEPTH];
   logic [AW:0]         len_clamp;
   logic [PW-1:0]       tape_len;
   logic [6*DIGITS-1:0] win;

   // Message buffer; reset fills every entry with blanks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < MSG_DEPTH; k++) mem[k] <= BLANK;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign len_clamp = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
   assign tape_len  = PW'(len_q) + PW'(DIGITS);

   // Window from the current position. A single conditional subtract wraps
   // the index because pos < L and i < DIGITS <= L. A write landing this
   // cycle is forwarded so it shows up in the window registered on this edge.
   always_comb begin
      logic [PW-1:0] idx;
      logic [5:0]    code;
      win = ALL_BLANK;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         idx = pos + PW'(i);
         if (idx >= tape_len) idx = idx - tape_len;
         if (idx < PW'(len_q)) begin
            if (wr_en && (wr_addr == idx[AW-1:0])) code = wr_data;
            else                                   code = mem[idx[AW-1:0]];
         end else begin
            code = BLANK;
         end
         win[6*(DIGITS-1-i) +: 6] = code;
      end
   end

   always_comb begin
      state_d = state;
      pos_d   = pos;
      cnt_d   = cnt;
      len_d   = len_q;
      wrap_d  = 1'b0;
      char_d  = ALL_BLANK;
      case (state)
         IDLE: begin
            if (start && !stop && (msg_len != '0)) begin
               state_d = RUN;
               pos_d   = '0;
               cnt_d   = '0;
               len_d   = len_clamp;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               pos_d   = '0;
               cnt_d   = '0;
            end else begin
               char_d = win;
               if (start && (msg_len != '0)) begin
                  pos_d = '0;
                  cnt_d = '0;
                  len_d = len_clamp;
               end else if (cnt == CNT_LAST) begin
                  cnt_d = '0;
                  if (pos == tape_len - PW'(1)) begin
                     pos_d  = '0;
                     wrap_d = 1'b1;
                  end else begin
                     pos_d = pos + PW'(1);
                  end
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pos      <= '0;
         cnt      <= '0;
         len_q    <= '0;
         char_out <= ALL_BLANK;
         wrap     <= 1'b0;
      end else begin
         state    <= state_d;
         pos      <= pos_d;
         cnt      <= cnt_d;
         len_q    <= len_d;
         char_out <= char_d;
         wrap     <= wrap_d;
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_text_scroller.sv
module tb_text_scroller;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [5:0]  wr_data;
   logic [4:0]  msg_len;
   logic        start;
   logic        stop;
   logic [23:0] char_out;
   logic        busy;
   logic        wrap;

   int vectors;
   int miscompares;

   localparam logic [23:0] BLANKS = {4{6'h3F}};
   localparam logic [23:0] W_POS0 = {6'h11, 6'h0E, 6'h15, 6'h15};
   localparam logic [23:0] W_POS1 = {6'h0E, 6'h15, 6'h15, 6'h18};
   localparam logic [23:0] W_POS3 = {6'h15, 6'h18, 6'h3F, 6'h3F};
   localparam logic [23:0] W_POS8 = {6'h3F, 6'h11, 6'h0E, 6'h15};
   localparam logic [23:0] W_LIVE = {6'h11, 6'h0A, 6'h15, 6'h15};

   text_scroller #(
      .DIGITS   (4),
      .MSG_DEPTH(16),
      .TICK_DIV (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .msg_len (msg_len),
      .start   (start),
      .stop    (stop),
      .char_out(char_out),
      .busy    (busy),
      .wrap    (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raise start during cycle N; returns at the negedge of cycle N+1.
   task automatic pulse_start(input logic [4:0] len);
      msg_len = len;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic load_hello();
      logic [5:0] txt [5];
      txt = '{6'h11, 6'h0E, 6'h15, 6'h15, 6'h18};
      for (int k = 0; k < 5; k++) begin
         wr_en   = 1'b1;
         wr_addr = 4'(k);
         wr_data = txt[k];
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cycles(3);
      vectors++;
      if (char_out !== BLANKS) begin
         miscompares++;
         $display("FAIL reset_char_out got %h exp %h", char_out, BLANKS);
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy got %b exp 0", busy);
      end
      vectors++;
      if (wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_wrap got %b exp 0", wrap);
      end
      rst_n = 1'b1;
      cycles(1);
      // Full 16-entry message: windows at pos 0,4,8,12 cover every entry.
      pulse_start(5'd16);
      for (int w = 0; w < 4; w++) begin
         cycles(w == 0 ? 1 : 16);
         vectors++;
         if (char_out !== BLANKS) begin
            miscompares++;
            $display("FAIL reset_buffer_win%0d got %h exp %h", w, char_out, BLANKS);
         end
      end
      pulse_stop();
   endtask

   task automatic test_scroll_hello();
      load_hello();
      pulse_start(5'd5);                  // now in N+1
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL hello_busy got %b exp 1", busy);
      end
      vectors++;
      if (char_out !== BLANKS) begin
         miscompares++;
         $display("FAIL hello_n1_blank got %h exp %h", char_out, BLANKS);
      end
      cycles(1);                          // N+2
      vectors++;
      if (char_out !== W_POS0) begin
         miscompares++;
         $display("FAIL hello_win0 got %h exp %h", char_out, W_POS0);
      end
      cycles(3);                          // N+5
      vectors++;
      if (char_out !== W_POS0) begin
         miscompares++;
         $display("FAIL hello_win0_hold got %h exp %h", char_out, W_POS0);
      end
      cycles(1);                          // N+6
      vectors++;
      if (char_out !== W_POS1) begin
         miscompares++;
         $display("FAIL hello_win1 got %h exp %h", char_out, W_POS1);
      end
      cycles(16);                         // N+22
      vectors++;
      if (char_out !== BLANKS) begin
         miscompares++;
         $display("FAIL hello_win5 got %h exp %h", char_out, BLANKS);
      end
      cycles(12);                         // N+34
      vectors++;
      if (char_out !== W_POS8) begin
         miscompares++;
         $display("FAIL hello_win8 got %h exp %h", char_out, W_POS8);
      end
      cycles(2);                          // N+36
      vectors++;
      if (wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL hello_wrap_early got %b exp 0", wrap);
      end
      cycles(1);                          // N+37
      vectors++;
      if (wrap !== 1'b1) begin
         miscompares++;
         $display("FAIL hello_wrap got %b exp 1", wrap);
      end
      cycles(1);                          // N+38
      vectors++;
      if (wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL hello_wrap_width got %b exp 0", wrap);
      end
      vectors++;
      if (char_out !== W_POS0) begin
         miscompares++;
         $display("FAIL hello_win0_again got %h exp %h", char_out, W_POS0);
      end
      pulse_stop();
   endtask

   task automatic test_zero_length();
      pulse_start(5'd0);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (busy !== 1'b0 || char_out !== BLANKS) begin
            miscompares++;
            $display("FAIL zero_len_c%0d got busy=%b char=%h exp busy=0 char=%h",
                     k, busy, char_out, BLANKS);
         end
         cycles(1);
      end
   endtask

   task automatic test_length_clamp();
      int first_wrap;
      int second_wrap;
      first_wrap  = -1;
      second_wrap = -1;
      msg_len = 5'd20;
      start   = 1'b1;
      for (int i = 1; i <= 200 && second_wrap < 0; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (wrap === 1'b1) begin
            if (first_wrap < 0) first_wrap = i;
            else                second_wrap = i;
         end
      end
      vectors++;
      if (first_wrap != 81) begin
         miscompares++;
         $display("FAIL clamp_first_wrap got %0d exp 81", first_wrap);
      end
      vectors++;
      if (second_wrap - first_wrap != 80) begin
         miscompares++;
         $display("FAIL clamp_wrap_period got %0d exp 80", second_wrap - first_wrap);
      end
      pulse_stop();
   endtask

   task automatic test_start_stop_collision();
      pulse_start(5'd5);
      cycles(5);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      vectors++;
      if (busy !== 1'b0 || char_out !== BLANKS) begin
         miscompares++;
         $display("FAIL collision got busy=%b char=%h exp busy=0 char=%h",
                  busy, char_out, BLANKS);
      end
      // Restart while pos = 3 (second cycle of that step).
      pulse_start(5'd5);                  // N+1
      cycles(13);                         // N+14
      vectors++;
      if (char_out !== W_POS3) begin
         miscompares++;
         $display("FAIL restart_pos3_win got %h exp %h", char_out, W_POS3);
      end
      pulse_start(5'd5);                  // M+1
      vectors++;
      if (char_out !== W_POS3) begin
         miscompares++;
         $display("FAIL restart_m1 got %h exp %h", char_out, W_POS3);
      end
      cycles(1);                          // M+2
      vectors++;
      if (char_out !== W_POS0) begin
         miscompares++;
         $display("FAIL restart_win0 got %h exp %h", char_out, W_POS0);
      end
      cycles(3);                          // M+5
      vectors++;
      if (char_out !== W_POS0) begin
         miscompares++;
         $display("FAIL restart_cnt_hold got %h exp %h", char_out, W_POS0);
      end
      cycles(1);                          // M+6
      vectors++;
      if (char_out !== W_POS1) begin
         miscompares++;
         $display("FAIL restart_cnt_step got %h exp %h", char_out, W_POS1);
      end
      pulse_stop();
   endtask

   task automatic test_live_write();
      pulse_start(5'd5);
      cycles(1);                          // window 0 showing
      wr_en   = 1'b1;
      wr_addr = 4'd1;
      wr_data = 6'h0A;
      @(negedge clk);
      wr_en   = 1'b0;
      vectors++;
      if (char_out !== W_LIVE) begin
         miscompares++;
         $display("FAIL live_write got %h exp %h", char_out, W_LIVE);
      end
   endtask

   task automatic test_async_reset();
      cycles(2);                          // still scrolling
      #2;
      rst_n = 1'b0;
      #1;                                 // before the next rising edge
      vectors++;
      if (char_out !== BLANKS || busy !== 1'b0 || wrap !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset got char=%h busy=%b wrap=%b exp char=%h busy=0 wrap=0",
                  char_out, busy, wrap, BLANKS);
      end
      cycles(2);
      rst_n = 1'b1;
      cycles(1);
      pulse_start(5'd5);
      cycles(1);
      vectors++;
      if (char_out !== BLANKS) begin
         miscompares++;
         $display("FAIL async_reset_buffer got %h exp %h", char_out, BLANKS);
      end
      pulse_stop();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      msg_len = '0;
      start   = 1'b0;
      stop    = 1'b0;
      test_reset();
      test_scroll_hello();
      test_zero_length();
      test_length_clamp();
      test_start_stop_collision();
      test_live_write();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
